// File: rtl/alignp_transmit.sv
// rtl/alignp_transmit.sv - serial transmitter for a 40-bit 8b/10b primitive with electrical idle
//
// Sends a pre-encoded primitive one bit per clock while burst_en is high.
// Characters go out in order 0..N-1, and each character is sent MSB first.
// While burst_en is low, both lines are held at 0 (electrical idle).
// P_BITS must be a multiple of CHAR_BITS.
//
// Ports:
//   clk      - serial bit clock; one bit per rising edge
//   reset    - asynchronous, active-high reset
//   burst_en - 1 = transmit the primitive stream, 0 = electrical idle
//   data_p   - primitive to send; character k is data_p[CHAR_BITS*k +: CHAR_BITS]
//   tx_p     - positive serial line (registered)
//   tx_n     - negative serial line (registered)

module alignp_transmit #(
    parameter int P_BITS    = 40,
    parameter int CHAR_BITS = 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              burst_en,
    input  logic [P_BITS-1:0] data_p,
    output logic              tx_p,
    output logic              tx_n
);

    localparam int IW = (P_BITS > 1) ? $clog2(P_BITS) : 1;
    localparam int PW = (CHAR_BITS > 1) ? $clog2(CHAR_BITS) : 1;

    localparam logic [IW-1:0] LAST_BASE = IW'(P_BITS - CHAR_BITS);
    localparam logic [IW-1:0] CHAR_STEP = IW'(CHAR_BITS);
    localparam logic [IW-1:0] CHAR_MSB  = IW'(CHAR_BITS - 1);
    localparam logic [PW-1:0] LAST_POS  = PW'(CHAR_BITS - 1);

    // The bit counter is held as two parts: the base of the current
    // character (a multiple of CHAR_BITS) and the position inside that
    // character. Together they form bit_idx = base + pos. This split avoids
    // a divider when selecting the bit to send.
    logic [IW-1:0]     base_q, base_d;
    logic [PW-1:0]     pos_q, pos_d;
    logic [P_BITS-1:0] frame_q, frame_d;
    logic              tx_p_q, tx_p_d;
    logic              tx_n_q, tx_n_d;

    logic              frame_start;
    logic [IW-1:0]     sel;
    logic              next_bit;

    always_comb begin
        frame_start = (base_q == '0) && (pos_q == '0);
        // Within a character, the MSB is sent first.
        sel         = base_q + CHAR_MSB - IW'(pos_q);
        // Bit 0 is taken straight from data_p, because it is captured on this same edge.
        next_bit    = frame_start ? data_p[CHAR_BITS-1] : frame_q[sel];

        base_d  = base_q;
        pos_d   = pos_q;
        frame_d = frame_q;
        tx_p_d  = 1'b0;
        tx_n_d  = 1'b0;

        if (burst_en) begin
            if (frame_start) begin
                frame_d = data_p;
            end
            tx_p_d = next_bit;
            tx_n_d = ~next_bit;
            if (pos_q == LAST_POS) begin
                pos_d  = '0;
                base_d = (base_q == LAST_BASE) ? '0 : base_q + CHAR_STEP;
            end else begin
                pos_d  = pos_q + 1'b1;
            end
        end else begin
            // Idle: abandon any partial frame, so the next burst starts at bit 0.
            base_d = '0;
            pos_d  = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            base_q  <= '0;
            pos_q   <= '0;
            frame_q <= '0;
            tx_p_q  <= 1'b0;
            tx_n_q  <= 1'b0;
        end else begin
            base_q  <= base_d;
            pos_q   <= pos_d;
            frame_q <= frame_d;
            tx_p_q  <= tx_p_d;
            tx_n_q  <= tx_n_d;
        end
    end

    assign tx_p = tx_p_q;
    assign tx_n = tx_n_q;

endmodule

// File: tb/tb_alignp_transmit.sv
// tb/tb_alignp_transmit.sv - self-checking bench for alignp_transmit

module tb_alignp_transmit;

    localparam logic [39:0] ALIGNP = {10'b0010011100, 10'b0101010101,
                                      10'b0101010101, 10'b0011111010};
    localparam logic [39:0] SYNCP  = {10'b1010101010, 10'b1010101010,
                                      10'b1010100010, 10'b0011110011};

    logic        clk;
    logic        reset;
    logic        burst_en;
    logic [39:0] data_p;
    logic        tx_p;
    logic        tx_n;

    int tests = 0;
    int fails = 0;

    // Reference model state
    int          mk;
    logic [39:0] mframe;
    logic        exp_p;
    logic        exp_n;
    logic        prev_burst;

    logic [9:0]  k285;
    logic [9:0]  k283;
    logic [63:0] rnd;

    alignp_transmit #(.P_BITS(40), .CHAR_BITS(10)) dut (
        .clk      (clk),
        .reset    (reset),
        .burst_en (burst_en),
        .data_p   (data_p),
        .tx_p     (tx_p),
        .tx_n     (tx_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic act, input logic exp);
        tests++;
        assert (act === exp) else begin
            fails++;
            $error("FAIL %s: observed %b expected %b", tag, act, exp);
        end
    endtask

    // One frame is a 40-bit sequence. Bit i is character i/10, sent MSB first.
    // The frame is captured when a new frame starts.
    task automatic model_step();
        logic b;
        prev_burst = burst_en;
        if (reset) begin
            mk = 0; mframe = '0; exp_p = 1'b0; exp_n = 1'b0;
        end else if (burst_en) begin
            if (mk == 0) mframe = data_p;
            b = mframe[10*(mk/10) + 9 - (mk%10)];
            exp_p = b; exp_n = ~b;
            mk = (mk + 1) % 40;
        end else begin
            mk = 0; exp_p = 1'b0; exp_n = 1'b0;
        end
    endtask

    task automatic tick(input string tag);
        @(posedge clk);
        model_step();
        #1;
        check({tag, "_tx_p"}, tx_p, exp_p);
        check({tag, "_tx_n"}, tx_n, exp_n);
    endtask

    initial begin
        k285 = 10'b0011111010;
        k283 = 10'b0011110011;
        mk = 0; mframe = '0; exp_p = 1'b0; exp_n = 1'b0; prev_burst = 1'b0;
        reset = 1'b1; burst_en = 1'b1; data_p = ALIGNP;

        // Reset held with burst enabled: lines stay idle.
        for (int i = 0; i < 4; i++) begin
            tick("reset_hold");
            check("reset_hold_p0", tx_p, 1'b0);
        end
        reset = 1'b0;

        // ALIGNp stream: 80 bits, first character checked against K28.5 directly.
        for (int i = 0; i < 80; i++) begin
            tick("alignp");
            if (i < 10) check("alignp_k285", tx_p, k285[9-i]);
        end

        // SYNCp switch at bit 17: the current frame completes as ALIGNp.
        for (int i = 0; i < 17; i++) tick("switch_pre");
        data_p = SYNCP;
        for (int i = 17; i < 40; i++) begin
            tick("switch_mid");
            if (i == 20) check("switch_still_alignp", tx_p, 1'b0);
            if (i == 21) check("switch_still_alignp", tx_p, 1'b1);
        end
        for (int i = 0; i < 10; i++) begin
            tick("syncp");
            check("syncp_k283", tx_p, k283[9-i]);
        end

        // Asynchronous reset mid-frame: lines drop before the next edge.
        for (int i = 0; i < 5; i++) tick("pre_async");
        #2 reset = 1'b1;
        #1;
        check("async_reset_p", tx_p, 1'b0);
        check("async_reset_n", tx_n, 1'b0);
        tick("in_reset");
        reset = 1'b0;

        // OOB bursts: 160 on / 480 off, six times.
        data_p = ALIGNP;
        for (int b = 0; b < 6; b++) begin
            burst_en = 1'b1;
            for (int i = 0; i < 160; i++) begin
                tick("oob_burst");
                if (i < 10) check("oob_start_k285", tx_p, k285[9-i]);
            end
            burst_en = 1'b0;
            for (int i = 0; i < 480; i++) begin
                tick("oob_idle");
                if (i == 0 || i == 479) begin
                    check("oob_idle_p", tx_p, 1'b0);
                    check("oob_idle_n", tx_n, 1'b0);
                end
            end
        end

        // Interrupted frame: 25 on, 1 off, then restart from bit 0.
        burst_en = 1'b1;
        for (int i = 0; i < 25; i++) tick("intr_pre");
        burst_en = 1'b0;
        tick("intr_gap");
        check("intr_gap_p", tx_p, 1'b0);
        check("intr_gap_n", tx_n, 1'b0);
        burst_en = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick("intr_restart");
            check("intr_restart_k285", tx_p, k285[9-i]);
        end

        // Random data and random burst enable; check the line invariant and the model.
        for (int i = 0; i < 10000; i++) begin
            if ($urandom_range(0, 6) == 0) begin
                rnd = {$urandom(), $urandom()};
                data_p = rnd[39:0];
            end
            burst_en = ($urandom_range(0, 15) != 0);
            tick("random");
            if (prev_burst) check("rand_complement", tx_n, ~tx_p);
            else begin
                check("rand_idle_p", tx_p, 1'b0);
                check("rand_idle_n", tx_n, 1'b0);
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
